// File: rtl/scr1_tcm_port_ctrl.sv
// TCM port controller: single-cycle core request -> memory strobes, response one cycle later.
// Optional zero-init sequencer enabled by SCR1_TCM_INIT_EN.
module scr1_tcm_port_ctrl #(
  parameter int unsigned SCR1_WIDTH = 32,
  parameter int unsigned SCR1_SIZE  = 32'h0001_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req,
  output logic                          o_req_ack,
  input  logic                          i_cmd,
  input  logic [1:0]                    i_width,
  input  logic [31:0]                   i_addr,
  input  logic [SCR1_WIDTH-1:0]         i_wdata,
  output logic [SCR1_WIDTH-1:0]         o_rdata,
  output logic [1:0]                    o_resp,
  output logic                          o_rena,
  output logic                          o_wena,
  output logic [3:0]                    o_weba,
  output logic [$clog2(SCR1_SIZE)-3:0]  o_addra,
  output logic [SCR1_WIDTH-1:0]         o_dataa,
  input  logic [SCR1_WIDTH-1:0]         i_qa,
  output logic                          o_init_done
);

  localparam int unsigned AW  = $clog2(SCR1_SIZE);
  localparam int unsigned WAW = AW - 2;

  logic           w_ready;
  logic           w_init;
  logic [WAW-1:0] w_init_addr;
  logic           w_illegal;
  logic           w_accept;
  logic           w_legal;
  logic [1:0]     w_off;
  logic           w_unused_addr;

`ifdef SCR1_TCM_INIT_EN
  typedef enum logic {StInit, StReady} state_e;

  state_e         r_state;
  logic [WAW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StInit: begin
          if (r_cnt == WAW'(SCR1_SIZE / 4 - 1)) r_state <= StReady;
          else                                  r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= StReady;
      endcase
    end
  end

  assign w_ready     = (r_state == StReady);
  assign w_init      = rst_n && (r_state == StInit);
  assign w_init_addr = r_cnt;
  assign o_init_done = w_ready;
`else
  // No sequencer: the port is usable as soon as reset is released.
  assign w_ready     = rst_n;
  assign w_init      = 1'b0;
  assign w_init_addr = '0;
  assign o_init_done = 1'b1;
`endif

  assign o_req_ack     = w_ready;
  assign w_off         = i_addr[1:0];
  assign w_unused_addr = ^i_addr[31:AW];

  assign w_illegal = (i_width == 2'b11)
                  || ((i_width == 2'b01) && i_addr[0])
                  || ((i_width == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_accept  = i_req && w_ready;
  assign w_legal   = w_accept && !w_illegal;

  always_comb begin
    o_rena  = 1'b0;
    o_wena  = 1'b0;
    o_weba  = 4'h0;
    o_addra = '0;
    o_dataa = '0;
    if (w_init) begin
      o_wena  = 1'b1;
      o_weba  = 4'hF;
      o_addra = w_init_addr;
    end else if (w_legal) begin
      o_addra = i_addr[AW-1:2];
      if (i_cmd) begin
        o_wena  = 1'b1;
        o_dataa = i_wdata << {w_off, 3'b000};
        case (i_width)
          2'b00:   o_weba = 4'b0001 << w_off;
          2'b01:   o_weba = 4'b0011 << w_off;
          default: o_weba = 4'b1111;
        endcase
      end else begin
        o_rena = 1'b1;
      end
    end
  end

  logic [1:0]            r_resp;
  logic                  r_rd;
  logic [1:0]            r_off;
  logic [1:0]            r_width;
  logic [SCR1_WIDTH-1:0] r_rdata;
  logic [SCR1_WIDTH-1:0] w_shift;
  logic [SCR1_WIDTH-1:0] w_rdata_fmt;

  assign w_shift = i_qa >> {r_off, 3'b000};

  always_comb begin
    case (r_width)
      2'b00:   w_rdata_fmt = {{(SCR1_WIDTH - 8){1'b0}}, w_shift[7:0]};
      2'b01:   w_rdata_fmt = {{(SCR1_WIDTH - 16){1'b0}}, w_shift[15:0]};
      default: w_rdata_fmt = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp  <= 2'b00;
      r_rd    <= 1'b0;
      r_off   <= 2'b00;
      r_width <= 2'b00;
      r_rdata <= '0;
    end else begin
      r_resp <= w_accept ? (w_illegal ? 2'b10 : 2'b01) : 2'b00;
      r_rd   <= w_legal && !i_cmd;
      if (w_accept) begin
        r_off   <= w_off;
        r_width <= i_width;
      end
      if (r_rd) r_rdata <= w_rdata_fmt;
    end
  end

  // qa is only valid in the response cycle; r_rdata keeps it visible afterwards.
  assign o_rdata = r_rd ? w_rdata_fmt : r_rdata;
  assign o_resp  = r_resp;

endmodule

// File: doc/scr1_tcm_port_ctrl.md
SCR1_TCM_PORT_CTRL -- requirements
Module: scr1_tcm_port_ctrl

Interface
REQ-001 SHALL have parameter SCR1_WIDTH, default 32: data width; only 32 is supported.
REQ-002 SHALL have parameter SCR1_SIZE, default 'h00010000: TCM size in bytes; power of two, at least 'h100.
REQ-003 SHALL have clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have core-side ports: req in 1 (request valid); req_ack out 1 (accepted when req && req_ack); cmd in 1 (0 read, 1 write); width in 2 (00 byte, 01 half, 10 word, 11 illegal); addr in 32 (byte address, low $clog2(SCR1_SIZE) bits used); wdata in 32 (LSB-aligned write data).
REQ-006 SHALL have core-side response ports: rdata out 32 (LSB-aligned read data); resp out 2 (00 idle, 01 ready, 10 error).
REQ-007 SHALL have memory-side ports, all outputs: rena 1; wena 1; weba 4 (byte enables); addra $clog2(SCR1_SIZE)-2 (word address); dataa 32 (write data).
REQ-008 SHALL have memory-side port qa in 32: read data, valid the cycle after rena.
REQ-009 SHALL have init_done out 1: high once the port is in READY.

Function
REQ-010 SHALL implement states INIT and READY; in READY, req_ack = 1 and accepts one request per cycle, back-to-back.
REQ-011 SHALL drive rena/wena/weba/addra/dataa combinationally in the cycle a legal request is accepted (cycle N); memory outputs are 0 when no access occurs.
REQ-012 SHALL treat as illegal: width = 11; half with addr[0] = 1; word with addr[1:0] != 0.
REQ-013 SHALL, for an illegal request, assert neither rena nor wena, and return resp = 10 in cycle N+1.
REQ-014 SHALL, for a legal read, assert rena only and return resp = 01 in cycle N+1, with rdata = qa >> (8*addr[1:0]); addr[1:0] is registered in cycle N.
REQ-015 SHALL zero-extend read data above the access width: byte to bits 7:0, half to bits 15:0.
REQ-016 SHALL, for a legal write, assert wena only, with dataa = wdata << (8*addr[1:0]).
REQ-017 SHALL, for a write, drive weba as follows: byte 4'b0001 << addr[1:0]; half 4'b0011 << addr[1:0]; word 4'b1111.
REQ-018 SHALL return resp = 01 for a write in cycle N+1.
REQ-019 SHALL drive resp = 00 in any cycle with no response due; rdata SHALL hold its last value when resp != 01 for a read.
REQ-020 SHALL ignore address bits at and above $clog2(SCR1_SIZE), so accesses wrap modulo SCR1_SIZE.
REQ-021 SHALL hold req_ack = 0 in INIT; a request in INIT is not accepted and produces no response.

Reset
REQ-022 SHALL, on rst_n low, immediately force: resp = 00; rdata = 0; rena = wena = 0; weba = 0; registered offset = 0.
REQ-023 SHALL, on rst_n low, force init counter = 0 and state = INIT (macro defined) or READY (macro undefined).
REQ-024 SHALL discard any response pending when reset asserts mid-operation; the first cycle after deassertion has resp = 00.

Configuration
REQ-025 SHALL use macro SCR1_TCM_INIT_EN to enable the zero-init sequencer.
REQ-026 SHALL, with SCR1_TCM_INIT_EN defined, in INIT drive wena = 1, weba = 4'hF, dataa = 0, addra = counter.
REQ-027 SHALL, with SCR1_TCM_INIT_EN defined, increment the counter each cycle from 0 to SCR1_SIZE/4-1, then enter READY; init takes exactly SCR1_SIZE/4 cycles.
REQ-028 SHALL, with SCR1_TCM_INIT_EN defined, set init_done = 0 in INIT and 1 in READY.
REQ-029 SHALL, without SCR1_TCM_INIT_EN, have no INIT state, no counter, init_done tied to 1, and req_ack = 1 from the first cycle after reset.

Verification
REQ-030 Bench SHALL check: word write addr 'h8, wdata 'hDEADBEEF, then read addr 'h8 -> wena/weba 4'hF, addra 2 in cycle N; read resp 01, rdata 'hDEADBEEF.
REQ-031 Bench SHALL check: byte write 'hA5 to addr 'h13 -> weba 4'b1000, dataa 'hA5000000; byte read 'h13 -> rdata 'h000000A5.
REQ-032 Bench SHALL check: half read addr 'h5 and word read addr 'h2 -> no rena; resp 10 next cycle.
REQ-033 Bench SHALL check: back-to-back reads 'h0, 'h4, 'h8 in consecutive cycles -> three consecutive resp 01 cycles with matching data.
REQ-034 Bench SHALL check, with SCR1_TCM_INIT_EN and SCR1_SIZE 'h100: req_ack = 0 for 64 cycles, writes to addra 0..63; then init_done = 1 and read of any addr returns 0.
REQ-035 Bench SHALL check: rst_n pulsed low the cycle after a read is accepted -> resp 00 and rdata 0 while reset is low and in the first cycle after release.
